gpio_input_conditioner: RTL and testbench
=========================================

// Module: gpio_input_conditioner
// PURPOSE
//   Conditions raw board buttons/switches before the CPU sees them: 2-flop synchronizer, per-bit
//   counter debouncer, rise/fall edge detect, sticky edge flags. Sits between the z1top pins
//   (btn, sw) and the CPU MMIO bus; exposes levels and W1C edge flags as 32-bit readable registers.
// PARAMETERS
//   N_BTN            4        number of push-button inputs
//   N_SW             4        number of slide-switch inputs
//   DEBOUNCE_CYCLES  1000000  consecutive disagreeing samples before stable level changes (>=2)
// PORTS
//   clk        in   1               system clock (100 MHz)
//   ck_rst     in   1               asynchronous active-low reset
//   btn        in   N_BTN           raw asynchronous button pins
//   sw         in   N_SW            raw asynchronous switch pins
//   level_o    out  W=N_SW+N_BTN    debounced levels, {sw,btn}
//   rise_o     out  W               1-cycle pulse per bit on debounced 0->1
//   fall_o     out  W               1-cycle pulse per bit on debounced 1->0
//   bus_addr   in   4               byte address within block (bits[1:0] ignored)
//   bus_re     in   1               read strobe
//   bus_we     in   1               write strobe
//   bus_wdata  in   32              write data
//   bus_rdata  out  32              read data, valid cycle after bus_re
//   irq_o      out  1               interrupt request (see CONFIGURATION)
// BEHAVIOUR
//   Reset (ck_rst=0, async): sync flops, counters, level_o, sticky regs, bus_rdata, irq_o all 0.
//   Sync: raw input -> s1 -> s2, one flop each per clk; no logic between s1 and s2.
//   Debounce, per bit: if s2==level: cnt<=0. Else if cnt==DEBOUNCE_CYCLES-1: level<=s2, cnt<=0;
//     else cnt<=cnt+1. cnt width = $clog2(DEBOUNCE_CYCLES); never wraps.
//   Latency: raw held from edge 0 -> level_o updates at edge DEBOUNCE_CYCLES+2.
//   Glitch shorter than DEBOUNCE_CYCLES samples: counter clears on return, no level change.
//   rise_o/fall_o: registered, high exactly the cycle level_o first shows new value.
//   Sticky RISE/FALL regs: bit set on rise_o/fall_o; cleared by write-1 at its address.
//     Same-cycle set and clear on one bit: set wins (no lost edge).
//   Register map (word):
//     0x0 LEVEL  R   {zeros, level_o}
//     0x4 RISE   R/W1C
//     0x8 FALL   R/W1C
//     0xC IRQEN  R/W  (2W bits: [W-1:0] rise enable, [2W-1:W] fall enable)
//   Read: bus_rdata registered on bus_re, reflects state before same-edge updates; holds
//     last value when bus_re=0. Unused upper bits read 0. Writes to LEVEL ignored.
//   Simultaneous bus_re and bus_we to same address: read returns pre-write value.
//   Reset mid-debounce: counter discarded; level restarts at 0 after ck_rst release.
// CONFIGURATION
//   GPIO_IRQ_EN defined: IRQEN register implemented; irq_o registered,
//     irq_o = |(RISE & IRQEN[W-1:0]) | |(FALL & IRQEN[2W-1:W]); drops cycle after flags cleared.
//   GPIO_IRQ_EN undefined: no IRQEN storage, 0xC reads 0, writes ignored, irq_o tied 0.
// TESTING (DEBOUNCE_CYCLES=8, N_BTN=4, N_SW=4)
//   Reset: ck_rst=0 with btn=4'b1010, sw=4'b0101 -> level_o, bus_rdata, irq_o = 0; release ->
//     level_o=8'h5A at edge 10 after release, rise_o=8'h5A one cycle, RISE reads 0x5A.
//   Glitch: btn[0] high 5 cycles then low -> level_o, rise_o, RISE unchanged.
//   W1C race: write 0x4 data 0x02 on same edge as btn[1] rise_o -> RISE[1] stays 1;
//     next write 0x02 -> RISE reads 0x00.
//   Fall: hold btn[3] low 10 cycles after high -> fall_o[3] one pulse, FALL reads 0x08.
//   Bus: write 0x0 0xFF -> LEVEL unchanged; read 0x0 -> bus_rdata=level one cycle later.
//   IRQ (GPIO_IRQ_EN): IRQEN=0x01, btn[0] rise -> irq_o=1 next cycle; W1C RISE[0] -> irq_o=0;
//     without macro irq_o stays 0 and 0xC reads 0.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// Button/switch conditioner: 2-flop sync, per-bit counter debounce, edge pulses, W1C sticky flags, MMIO.
// Optional GPIO_IRQ_EN macro adds the IRQEN register and a registered interrupt output.
module gpio_input_conditioner #(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   ck_rst,
  input  logic [N_BTN-1:0]       btn,
  input  logic [N_SW-1:0]        sw,
  output logic [N_SW+N_BTN-1:0]  level_o,
  output logic [N_SW+N_BTN-1:0]  rise_o,
  output logic [N_SW+N_BTN-1:0]  fall_o,
  input  logic [3:0]             bus_addr,
  input  logic                   bus_re,
  input  logic                   bus_we,
  input  logic [31:0]            bus_wdata,
  output logic [31:0]            bus_rdata,
  output logic                   irq_o
);

  localparam int W  = N_SW + N_BTN;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [W-1:0]  raw_s;
  logic [W-1:0]  s1_r;
  logic [W-1:0]  s2_r;
  logic [W-1:0]  level_r;
  logic [W-1:0]  level_nxt_s;
  logic [W-1:0]  rise_set_s;
  logic [W-1:0]  fall_set_s;
  logic [W-1:0]  rise_r;
  logic [W-1:0]  fall_r;
  logic [W-1:0]  rise_flag_r;
  logic [W-1:0]  fall_flag_r;
  logic [W-1:0]  rise_clr_s;
  logic [W-1:0]  fall_clr_s;
  logic [CW-1:0] cnt_r     [W];
  logic [CW-1:0] cnt_nxt_s [W];
  logic [31:0]   rd_mux_s;
  logic [31:0]   rdata_r;
  logic          unused_s;

  assign raw_s = {sw, btn};

  // Two-stage synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      s1_r <= {W{1'b0}};
      s2_r <= {W{1'b0}};
    end else begin
      s1_r <= raw_s;
      s2_r <= s1_r;
    end
  end

  // Debounce next-state: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    level_nxt_s = level_r;
    for (int i = 0; i < W; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (s2_r[i] == level_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_MAX) begin
        level_nxt_s[i] = s2_r[i];
        cnt_nxt_s[i]   = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  assign rise_set_s = level_nxt_s & ~level_r;
  assign fall_set_s = ~level_nxt_s & level_r;

  // Debounce state plus edge pulses aligned with the level change
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      level_r <= {W{1'b0}};
      rise_r  <= {W{1'b0}};
      fall_r  <= {W{1'b0}};
      for (int i = 0; i < W; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      level_r <= level_nxt_s;
      rise_r  <= rise_set_s;
      fall_r  <= fall_set_s;
      for (int i = 0; i < W; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Write-1-to-clear decode for the sticky flag registers
  always_comb begin
    rise_clr_s = {W{1'b0}};
    fall_clr_s = {W{1'b0}};
    if (bus_we && (bus_addr[3:2] == 2'd1)) begin
      rise_clr_s = bus_wdata[W-1:0];
    end else if (bus_we && (bus_addr[3:2] == 2'd2)) begin
      fall_clr_s = bus_wdata[W-1:0];
    end else begin
      rise_clr_s = {W{1'b0}};
      fall_clr_s = {W{1'b0}};
    end
  end

  // Sticky flags; set is applied after clear so a coincident edge is never lost
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      rise_flag_r <= {W{1'b0}};
      fall_flag_r <= {W{1'b0}};
    end else begin
      rise_flag_r <= (rise_flag_r & ~rise_clr_s) | rise_set_s;
      fall_flag_r <= (fall_flag_r & ~fall_clr_s) | fall_set_s;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [2*W-1:0] irqen_r;
  logic           irq_r;

  // Interrupt enable register: rise enables low half, fall enables high half
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      irqen_r <= {(2*W){1'b0}};
    end else if (bus_we && (bus_addr[3:2] == 2'd3)) begin
      irqen_r <= bus_wdata[2*W-1:0];
    end else begin
      irqen_r <= irqen_r;
    end
  end

  // Registered interrupt, follows the flag registers one cycle later
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (|(rise_flag_r & irqen_r[W-1:0])) | (|(fall_flag_r & irqen_r[2*W-1:W]));
    end
  end

  assign irq_o = irq_r;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux sees pre-update state, so a same-edge write is not visible in the returned data
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus_addr[3:2])
      2'd0: rd_mux_s[W-1:0] = level_r;
      2'd1: rd_mux_s[W-1:0] = rise_flag_r;
      2'd2: rd_mux_s[W-1:0] = fall_flag_r;
`ifdef GPIO_IRQ_EN
      2'd3: rd_mux_s[2*W-1:0] = irqen_r;
`else
      2'd3: rd_mux_s = 32'h0000_0000;
`endif
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Read data register holds its value between read strobes
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      rdata_r <= 32'h0000_0000;
    end else if (bus_re) begin
      rdata_r <= rd_mux_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign level_o   = level_r;
  assign rise_o    = rise_r;
  assign fall_o    = fall_r;
  assign bus_rdata = rdata_r;
  assign unused_s  = ^{bus_addr[1:0], bus_wdata};

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed, table-driven bench for gpio_input_conditioner with DEBOUNCE_CYCLES=8.
module tb_gpio_input_conditioner;

  logic        clk;
  logic        ck_rst;
  logic [3:0]  btn;
  logic [3:0]  sw;
  logic [7:0]  level_o;
  logic [7:0]  rise_o;
  logic [7:0]  fall_o;
  logic [3:0]  bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  gpio_input_conditioner #(
    .N_BTN(4), .N_SW(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .ck_rst(ck_rst), .btn(btn), .sw(sw),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .bus_addr(bus_addr), .bus_re(bus_re), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  btn;
    logic [3:0]  sw;
    int          n;
    logic [7:0]  lvl;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    bus_addr = a;
    bus_re   = 1'b1;
    cyc(1);
    bus_re   = 1'b0;
    chk(nm, bus_rdata, exp);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    cyc(1);
    bus_we    = 1'b0;
  endtask

  initial begin
    //          btn    sw     n   level  rise   fall   rd    addr   rdata
    vecs[0]  = '{4'hA, 4'h5, 9,  8'h00, 8'h00, 8'h00, 1'b0, 4'h0, 32'h00};
    vecs[1]  = '{4'hA, 4'h5, 1,  8'h5A, 8'h5A, 8'h00, 1'b0, 4'h0, 32'h00};
    vecs[2]  = '{4'hA, 4'h5, 1,  8'h5A, 8'h00, 8'h00, 1'b1, 4'h4, 32'h5A};
    vecs[3]  = '{4'hB, 4'h5, 5,  8'h5A, 8'h00, 8'h00, 1'b0, 4'h0, 32'h00};
    vecs[4]  = '{4'hA, 4'h5, 10, 8'h5A, 8'h00, 8'h00, 1'b1, 4'h4, 32'h5A};
    vecs[5]  = '{4'h2, 4'h5, 9,  8'h5A, 8'h00, 8'h00, 1'b0, 4'h0, 32'h00};
    vecs[6]  = '{4'h2, 4'h5, 1,  8'h52, 8'h00, 8'h08, 1'b0, 4'h0, 32'h00};
    vecs[7]  = '{4'h2, 4'h5, 1,  8'h52, 8'h00, 8'h00, 1'b1, 4'h8, 32'h08};
    vecs[8]  = '{4'h2, 4'hF, 9,  8'h52, 8'h00, 8'h00, 1'b0, 4'h0, 32'h00};
    vecs[9]  = '{4'h2, 4'hF, 1,  8'hF2, 8'hA0, 8'h00, 1'b0, 4'h0, 32'h00};
    vecs[10] = '{4'h2, 4'hF, 1,  8'hF2, 8'h00, 8'h00, 1'b1, 4'h0, 32'hF2};
    vecs[11] = '{4'h0, 4'h0, 9,  8'hF2, 8'h00, 8'h00, 1'b0, 4'h0, 32'h00};
    vecs[12] = '{4'h0, 4'h0, 1,  8'h00, 8'h00, 8'hF2, 1'b0, 4'h0, 32'h00};
    vecs[13] = '{4'h0, 4'h0, 1,  8'h00, 8'h00, 8'h00, 1'b1, 4'h8, 32'hFA};

    ck_rst = 1'b0; btn = 4'hA; sw = 4'h5;
    bus_addr = 4'h0; bus_re = 1'b0; bus_we = 1'b0; bus_wdata = 32'h0;
    cyc(3);
    chk("reset level", {24'h0, level_o}, 32'h00);
    chk("reset rise", {24'h0, rise_o}, 32'h00);
    chk("reset rdata", bus_rdata, 32'h00);
    chk("reset irq", {31'h0, irq_o}, 32'h0);
    ck_rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      btn = vecs[i].btn;
      sw  = vecs[i].sw;
      cyc(vecs[i].n);
      chk($sformatf("v%0d level", i), {24'h0, level_o}, {24'h0, vecs[i].lvl});
      chk($sformatf("v%0d rise", i), {24'h0, rise_o}, {24'h0, vecs[i].rise});
      chk($sformatf("v%0d fall", i), {24'h0, fall_o}, {24'h0, vecs[i].fall});
      if (vecs[i].rd) begin
        do_read(vecs[i].addr, vecs[i].exp_rd, $sformatf("v%0d read", i));
      end
    end

    // clear all sticky flags
    do_write(4'h4, 32'hFF);
    do_read(4'h4, 32'h00, "rise cleared");
    do_write(4'h8, 32'hFF);
    do_read(4'h8, 32'h00, "fall cleared");

    // W1C on the same edge as a rising edge: set wins
    btn = 4'h2;
    cyc(9);
    chk("race pre level", {24'h0, level_o}, 32'h00);
    bus_addr = 4'h4; bus_wdata = 32'h02; bus_we = 1'b1;
    cyc(1);
    bus_we = 1'b0;
    chk("race rise_o", {24'h0, rise_o}, 32'h02);
    chk("race level", {24'h0, level_o}, 32'h02);
    // read and write same address same edge: read sees pre-write value
    bus_addr = 4'h4; bus_wdata = 32'h02; bus_we = 1'b1; bus_re = 1'b1;
    cyc(1);
    bus_we = 1'b0; bus_re = 1'b0;
    chk("rdwr pre-write", bus_rdata, 32'h02);
    do_read(4'h4, 32'h00, "rise after w1c");

    // LEVEL is read-only; rdata holds when bus_re is low
    do_write(4'h0, 32'hFF);
    do_read(4'h0, 32'h02, "level ro");
    bus_addr = 4'h4;
    cyc(1);
    chk("rdata hold", bus_rdata, 32'h02);

`ifdef GPIO_IRQ_EN
    do_write(4'hC, 32'h01);
    do_read(4'hC, 32'h01, "irqen read");
    chk("irq idle", {31'h0, irq_o}, 32'h0);
    btn = 4'h3;
    cyc(10);
    chk("irq rise_o", {24'h0, rise_o}, 32'h01);
    chk("irq not yet", {31'h0, irq_o}, 32'h0);
    cyc(1);
    chk("irq set", {31'h0, irq_o}, 32'h1);
    do_write(4'h4, 32'h01);
    chk("irq still", {31'h0, irq_o}, 32'h1);
    cyc(1);
    chk("irq drop", {31'h0, irq_o}, 32'h0);
`else
    do_write(4'hC, 32'h01);
    do_read(4'hC, 32'h00, "irqen absent");
    btn = 4'h3;
    cyc(12);
    chk("noirq level", {24'h0, level_o}, 32'h03);
    chk("noirq irq", {31'h0, irq_o}, 32'h0);
`endif

    // reset in the middle of a debounce count
    sw = 4'h1;
    cyc(5);
    ck_rst = 1'b0;
    #1;
    chk("midrst level", {24'h0, level_o}, 32'h00);
    chk("midrst rdata", bus_rdata, 32'h00);
    chk("midrst irq", {31'h0, irq_o}, 32'h0);
    @(negedge clk);
    ck_rst = 1'b1;
    cyc(9);
    chk("post-rst level early", {24'h0, level_o}, 32'h00);
    cyc(1);
    chk("post-rst level", {24'h0, level_o}, 32'h13);
    chk("post-rst rise", {24'h0, rise_o}, 32'h13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
